// File: rtl/adc_pmod.sv
// Dual-channel serial ADC (PMOD) frame sequencer feeding a byte-wide tracking FIFO.
// Optional feature: define ADC_PMOD_OVERFLOW_COUNT_EN to implement the dropped-frame counter.
module adc_pmod (
  input  logic        clk,
  input  logic        reset,
  output logic        fifo_clk,
  output logic [7:0]  fifo_data,
  output logic        fifo_write,
  input  logic [10:0] fifo_addr_in,
  input  logic [10:0] fifo_addr_out,
  output logic [1:0]  pmod_out,
  input  logic [1:0]  pmod_in,
  input  logic        enable,
  input  logic [3:0]  clkexp,
  input  logic [15:0] sample_period,
  output logic [7:0]  overflow_count
);

  // state   | meaning
  // IDLE    | waiting for a pending frame start
  // CONVERT | CS_n low, 16 SCLK periods shifting both channels in
  // WRITE   | 4 cycles pushing the frame into the FIFO (or dropping it)
  // QUIET   | CS_n high for 2H cycles before the next frame may start
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_QUIET   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] per_q, per_d;
  logic        pend_q, pend_d;
  logic [2:0]  hexp_q, hexp_d;
  logic [7:0]  tmr_q, tmr_d;
  logic [4:0]  edge_q, edge_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic [15:0] sh_a_q, sh_a_d;
  logic [15:0] sh_b_q, sh_b_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        wok_q, wok_d;

  logic [2:0]  hexp_new;
  logic [7:0]  half_new;
  logic [7:0]  half_cur;
  logic [8:0]  quiet_load;
  logic [10:0] used;
  logic [10:0] free;
  logic        room;
  logic        wrap;
  logic        start;
  logic        write_ok;

  assign hexp_new   = clkexp[3] ? 3'd7 : clkexp[2:0];
  assign half_new   = 8'd1 << hexp_new;
  assign half_cur   = 8'd1 << hexp_q;
  assign quiet_load = {half_cur, 1'b0} - 9'd1;

  // 11-bit subtraction gives the pointer distance modulo 2048 for free
  assign used  = fifo_addr_in - fifo_addr_out;
  assign free  = 11'h7FF - used;
  assign room  = (free >= 11'd4);

  // >= keeps the counter bounded if sample_period is lowered mid-count
  assign wrap  = (per_q >= sample_period);
  assign start = (state_q == ST_IDLE) && pend_q && enable;

  always_comb begin
    state_d = state_q;
    per_d   = wrap ? 16'd0 : per_q + 16'd1;
    pend_d  = pend_q;
    hexp_d  = hexp_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    wcnt_d  = wcnt_q;
    wok_d   = wok_q;

    if (!enable) begin
      pend_d = 1'b0;
    end else begin
      if (start) pend_d = 1'b0;
      if (wrap)  pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CONVERT;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b1;
          hexp_d  = hexp_new;
          tmr_d   = half_new - 8'd1;
          edge_d  = 5'd0;
        end
      end
      ST_CONVERT: begin
        if (tmr_q == 8'd0) begin
          tmr_d  = half_cur - 8'd1;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            sh_a_d = {sh_a_q[14:0], pmod_in[0]};
            sh_b_d = {sh_b_q[14:0], pmod_in[1]};
            edge_d = edge_q + 5'd1;
            if (edge_q == 5'd15) begin
              state_d = ST_WRITE;
              cs_n_d  = 1'b1;
              wcnt_d  = 2'd0;
            end
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_WRITE: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wcnt_q == 2'd0) wok_d = room;
        if (wcnt_q == 2'd3) begin
          state_d = ST_QUIET;
          tmr_d   = quiet_load[7:0];
        end
      end
      default: begin
        if (tmr_q == 8'd0) state_d = ST_IDLE;
        else               tmr_d   = tmr_q - 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      per_q   <= 16'd0;
      pend_q  <= 1'b0;
      hexp_q  <= 3'd0;
      tmr_q   <= 8'd0;
      edge_q  <= 5'd0;
      sclk_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      sh_a_q  <= 16'd0;
      sh_b_q  <= 16'd0;
      wcnt_q  <= 2'd0;
      wok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      hexp_q  <= hexp_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      wcnt_q  <= wcnt_d;
      wok_q   <= wok_d;
    end
  end

  // Room is judged on the first WRITE cycle and held so a frame is never split
  assign write_ok   = (wcnt_q == 2'd0) ? room : wok_q;
  assign fifo_write = (state_q == ST_WRITE) && write_ok;

  always_comb begin
    fifo_data = 8'd0;
    if (fifo_write) begin
      case (wcnt_q)
        2'd0:    fifo_data = sh_b_q[7:0];
        2'd1:    fifo_data = sh_b_q[15:8];
        2'd2:    fifo_data = sh_a_q[7:0];
        default: fifo_data = sh_a_q[15:8];
      endcase
    end
  end

`ifdef ADC_PMOD_OVERFLOW_COUNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((state_q == ST_WRITE) && (wcnt_q == 2'd0) && !room && (ovf_q != 8'hFF))
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 8'd0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_count = ovf_q;
`else
  assign overflow_count = 8'd0;
`endif

  assign fifo_clk = clk;
  assign pmod_out = {sclk_q, cs_n_q};

endmodule

// File: tb/tb_adc_pmod.sv
// Directed bench for adc_pmod: scoreboard of expected FIFO bytes plus a behavioural ADC.
module tb_adc_pmod;
  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_clk;
  logic [7:0]  fifo_data;
  logic        fifo_write;
  logic [10:0] fifo_addr_in;
  logic [10:0] fifo_addr_out;
  logic [1:0]  pmod_out;
  logic [1:0]  pmod_in = 2'b00;
  logic        enable;
  logic [3:0]  clkexp;
  logic [15:0] sample_period;
  logic [7:0]  overflow_count;

  adc_pmod dut (
    .clk(clk), .reset(reset), .fifo_clk(fifo_clk), .fifo_data(fifo_data),
    .fifo_write(fifo_write), .fifo_addr_in(fifo_addr_in), .fifo_addr_out(fifo_addr_out),
    .pmod_out(pmod_out), .pmod_in(pmod_in), .enable(enable), .clkexp(clkexp),
    .sample_period(sample_period), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [7:0]  exp_q[$];
  longint      wr_cyc[$];
  int          n_writes  = 0;
  int          n_cs_fall = 0;
  longint      cyc = 0;
  int          ovf_exp = 0;
  logic [15:0] da = 16'h0000;
  logic [15:0] db = 16'h0000;
  int          idx = 15;
  logic [1:0]  pmod_prev = 2'b11;
  logic        cs_prev = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [15:0] a, input logic [15:0] b);
    exp_q.push_back(b[7:0]);
    exp_q.push_back(b[15:8]);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(a[15:8]);
  endtask

  task automatic ovf_bump(input int n);
`ifdef ADC_PMOD_OVERFLOW_COUNT_EN
    ovf_exp = (ovf_exp + n > 255) ? 255 : ovf_exp + n;
`else
    ovf_exp = ovf_exp + 0 * n;
`endif
  endtask

  task automatic wait_writes(input int n, input int budget, input string tag);
    int k = 0;
    while (n_writes < n && k < budget) begin @(negedge clk); k++; end
    @(negedge clk);
    chk(tag, 32'(n_writes), 32'(n));
  endtask

  task automatic wait_cs_low(input int budget, input string tag);
    int k = 0;
    while (pmod_out[0] !== 1'b0 && k < budget) begin @(negedge clk); k++; end
    chk(tag, 32'(pmod_out[0]), 32'd0);
  endtask

  // ADC model: a new bit is presented on every SCLK fall, MSB first from CS_n fall
  always @(pmod_out) begin
    if (pmod_prev[0] && !pmod_out[0]) idx = 15;
    else if (!pmod_out[0] && pmod_prev[1] && !pmod_out[1]) begin
      if (idx >= 0) pmod_in = {db[idx], da[idx]};
      idx--;
    end
    pmod_prev = pmod_out;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [7:0] e;
    if (reset === 1'b1) begin
      if (fifo_write) begin
        n_writes++;
        wr_cyc.push_back(cyc);
        chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fifo_byte", 32'(fifo_data), 32'(e));
        end
      end else begin
        chk("data_idle_zero", 32'(fifo_data), 32'd0);
      end
    end
    if (cs_prev && !pmod_out[0]) n_cs_fall++;
    cs_prev = pmod_out[0];
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, run, rmin, rmax, falls, gap, nf, wbase, f0, frames, rises;
    logic prev;
    longint rel;
    logic [10:0] c_in [4];
    logic [10:0] c_out[4];
    logic        c_wr [4];

    reset = 1'b0; enable = 1'b0; clkexp = 4'd0; sample_period = 16'd99;
    fifo_addr_in = 11'd0; fifo_addr_out = 11'd0;
    da = 16'h0123; db = 16'h0ABC;
    repeat (3) @(negedge clk);
    chk("rst_pmod_out", 32'(pmod_out), 32'h3);
    chk("rst_fifo_write", 32'(fifo_write), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'd0);
    chk("rst_overflow", 32'(overflow_count), 32'd0);
    reset = 1'b1;

    // Basic frames, 100-cycle cadence
    repeat (3) push_frame(da, db);
    enable = 1'b1;
    wait_writes(12, 600, "frames_basic");
    enable = 1'b0;
    chk("burst_consecutive", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    chk("frame_period_1", 32'(wr_cyc[4] - wr_cyc[0]), 32'd100);
    chk("frame_period_2", 32'(wr_cyc[8] - wr_cyc[4]), 32'd100);
    repeat (300) @(negedge clk);
    chk("no_writes_after_disable", 32'(n_writes), 32'd12);

    // SCLK shape at H=4, back-to-back deferral, raw leading nibble kept
    da = 16'hF5A3; db = 16'h1E6C; clkexp = 4'd2;
    repeat (2) push_frame(da, db);
    enable = 1'b1;
    wait_cs_low(300, "cs_fall_h4");
    chk("sclk_high_at_cs_fall", 32'(pmod_out[1]), 32'd1);
    prev = pmod_out[1]; len = 1; run = 1; rmin = 1000; rmax = 0; falls = 0;
    while (len < 2000) begin
      @(negedge clk);
      if (pmod_out[0]) break;
      len++;
      if (pmod_out[1] == prev) run++;
      else begin
        if (run < rmin) rmin = run;
        if (run > rmax) rmax = run;
        run = 1;
        if (!pmod_out[1]) falls++;
      end
      prev = pmod_out[1];
    end
    if (run < rmin) rmin = run;
    if (run > rmax) rmax = run;
    chk("cs_low_len_h4", 32'(len), 32'd128);
    chk("sclk_pulses", 32'(falls), 32'd16);
    chk("sclk_run_min", 32'(rmin), 32'd4);
    chk("sclk_run_max", 32'(rmax), 32'd4);
    gap = 0;
    while (pmod_out[0] === 1'b1 && gap < 2000) begin gap++; @(negedge clk); end
    chk("cs_gap_min8", 32'(gap >= 8), 32'd1);
    chk("cs_gap_back_to_back", 32'(gap), 32'd13);
    // enable drops and clkexp changes mid-CONVERT: frame finishes at the old rate
    enable = 1'b0; clkexp = 4'd0;
    len = 1;
    while (len < 2000) begin
      @(negedge clk);
      if (pmod_out[0]) break;
      len++;
    end
    chk("clkexp_latched", 32'(len), 32'd128);
    wait_writes(20, 200, "frame_after_disable");
    nf = n_cs_fall;
    repeat (400) @(negedge clk);
    chk("no_cs_after_disable", 32'(n_cs_fall), 32'(nf));

    // Space boundary cases: drop when free < 4
    c_in[0] = 11'h7FE; c_out[0] = 11'h000; c_wr[0] = 1'b0;
    c_in[1] = 11'h002; c_out[1] = 11'h7FF; c_wr[1] = 1'b1;
    c_in[2] = 11'h7FB; c_out[2] = 11'h000; c_wr[2] = 1'b1;
    c_in[3] = 11'h7FC; c_out[3] = 11'h000; c_wr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fifo_addr_in = c_in[i]; fifo_addr_out = c_out[i];
      da = 16'h1000 + 16'(i * 16'h0111); db = 16'hC0DE ^ 16'(i);
      if (c_wr[i]) push_frame(da, db);
      else         ovf_bump(1);
      wbase = n_writes;
      enable = 1'b1;
      wait_cs_low(300, "cs_fall_space");
      enable = 1'b0;
      repeat (45) @(negedge clk);
      chk("space_writes", 32'(n_writes), 32'(wbase + (c_wr[i] ? 4 : 0)));
      chk("space_overflow", 32'(overflow_count), 32'(ovf_exp));
    end

    // Overflow saturation with the FIFO held full
    fifo_addr_in = 11'h7FF; fifo_addr_out = 11'h000; sample_period = 16'd39;
    f0 = n_cs_fall; wbase = n_writes;
    enable = 1'b1;
    for (int k = 0; k < 30000 && (n_cs_fall - f0) < 300; k++) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    frames = n_cs_fall - f0;
    chk("sat_frames", 32'(frames >= 300), 32'd1);
    ovf_bump(frames);
    chk("sat_overflow", 32'(overflow_count), 32'(ovf_exp));
    chk("sat_no_writes", 32'(n_writes), 32'(wbase));

    // Reset at the 8th SCLK rise aborts the frame
    fifo_addr_in = 11'd0; fifo_addr_out = 11'd0; sample_period = 16'd99;
    enable = 1'b1;
    wait_cs_low(300, "cs_fall_pre_reset");
    rises = 0; prev = pmod_out[1];
    for (int k = 0; k < 200 && rises < 8; k++) begin
      @(negedge clk);
      if (!prev && pmod_out[1]) rises++;
      prev = pmod_out[1];
    end
    wbase = n_writes;
    reset = 1'b0;
    #1;
    chk("abort_pmod_out", 32'(pmod_out), 32'h3);
    chk("abort_fifo_write", 32'(fifo_write), 32'd0);
    chk("abort_overflow", 32'(overflow_count), 32'd0);
    ovf_exp = 0;
    repeat (5) @(negedge clk);
    da = 16'h8421; db = 16'h7E81;
    push_frame(da, db);
    reset = 1'b1;
    rel = cyc;
    wait_cs_low(300, "cs_fall_post_reset");
    chk("first_start_at_wrap", 32'(cyc - rel), 32'd101);
    enable = 1'b0;
    wait_writes(wbase + 4, 100, "frame_after_reset");
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
